dualmem_portb_arb: RTL and testbench

- Round-robin burst arbiter that shares the 64-bit port B of the widening dual-port line buffer between two requesters (req 0: CPU/bus bridge, req 1: DMA engine).
- Each accepted request owns port B for a burst of 1..16 beats with auto-incrementing word address.
- The block drives the RAM's enb/web/addrb/dinb, captures doutb, and returns read data to the owning requester with a fixed 1-cycle latency.

---
 rtl/dualmem_pkg.sv | 18 +
 rtl/rr_arb2.sv | 20 ++
 rtl/dualmem_portb_arb.sv | 130 +++++++++++++
 tb/tb_dualmem_portb_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dualmem_pkg.sv
// Shared types and constants for the port-B burst arbiter.
// Imported by the arbiter top and its bench.
package dualmem_pkg;

  localparam int AW   = 11;
  localparam int DW   = 64;
  localparam int LENW = 4;

  localparam logic [1:0] WE_READ = 2'b00;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef logic [LENW-1:0] beat_cnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// On a tie the requester that did not own the last burst wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // one-hot winner from the request pair and priority pointer
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dualmem_portb_arb.sv
// Burst arbiter sharing RAM port B between CPU bridge (0) and DMA (1).
// Owns the port for len+1 beats, returns reads one cycle later.
module dualmem_portb_arb
  import dualmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [1:0][1:0]       we_i,
  input  logic [1:0][AW-1:0]    addr_i,
  input  logic [1:0][LENW-1:0]  len_i,
  input  logic [1:0][DW-1:0]    wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            beat_o,
  output logic [1:0]            done_o,
  output logic [1:0]            rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  enb_o,
  output logic [1:0]            web_o,
  output logic [AW-1:0]         addrb_o,
  output logic [DW-1:0]         dinb_o,
  input  logic [DW-1:0]         doutb_i
);

  state_t        state;
  state_t        state_n;
  logic          owner;
  logic [AW-1:0] addr;
  logic [1:0]    we;
  beat_cnt_t     cnt;
  logic          last;
  logic          rd_pend;
  logic          rd_owner;

  logic [1:0]    grant;
  logic          load;
  logic [1:0]    gnt;
  logic [1:0]    beat;
  logic [1:0]    done;
  logic          enb;
  logic [1:0]    web;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic [1:0]    rvalid;

  rr_arb2 u_arb (
    .req   (req_i),
    .last  (last),
    .grant (grant)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state and port-B drive
  always_comb begin
    state_n = state;
    load    = 1'b0;
    gnt     = 2'b00;
    beat    = 2'b00;
    done    = 2'b00;
    enb     = 1'b0;
    web     = 2'b00;
    addrb   = '0;
    dinb    = '0;
    unique case (state)
      IDLE: begin
        if (|req_i) begin
          gnt     = grant;
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        enb         = 1'b1;
        web         = we;
        addrb       = addr;
        dinb        = (we == WE_READ) ? '0 : wdata_i[owner];
        beat[owner] = 1'b1;
        if (cnt == '0) begin
          done[owner] = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // burst context, address/length counters, read return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      addr     <= '0;
      we       <= WE_READ;
      cnt      <= '0;
      last     <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (load) begin
        owner <= grant[1];
        addr  <= addr_i[grant[1]];
        we    <= we_i[grant[1]];
        cnt   <= len_i[grant[1]];
      end else if (state == BUSY) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) last <= owner;
      end
      rd_pend  <= (state == BUSY) && (we == WE_READ);
      rd_owner <= owner;
    end
  end

  assign rvalid = rd_pend ? (2'b01 << rd_owner) : 2'b00;

  assign gnt_o    = rst ? 2'b00 : gnt;
  assign beat_o   = rst ? 2'b00 : beat;
  assign done_o   = rst ? 2'b00 : done;
  assign enb_o    = rst ? 1'b0  : enb;
  assign web_o    = rst ? 2'b00 : web;
  assign addrb_o  = rst ? '0    : addrb;
  assign dinb_o   = rst ? '0    : dinb;
  assign rvalid_o = rst ? 2'b00 : rvalid;
  assign rdata_o  = (rst || !rd_pend) ? '0 : doutb_i;

endmodule

// File: tb/tb_dualmem_portb_arb.sv
// Directed bench for the port-B burst arbiter with a RAM model.
// Read data is scoreboarded against a reference memory image.
module tb_dualmem_portb_arb;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0][1:0]  wev;
  logic [1:0][10:0] addrv;
  logic [1:0][3:0]  lenv;
  logic [1:0][63:0] wdv;
  logic [1:0]       gnt_o;
  logic [1:0]       beat_o;
  logic [1:0]       done_o;
  logic [1:0]       rvalid_o;
  logic [63:0]      rdata_o;
  logic             enb_o;
  logic [1:0]       web_o;
  logic [10:0]      addrb_o;
  logic [63:0]      dinb_o;
  logic [63:0]      doutb;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        r;
    logic [63:0] d;
  } sb_t;

  sb_t sb[$];

  logic [63:0] ram [2048];
  bit          rw  [2048];
  logic [63:0] model [2048];
  bit          mw    [2048];

  dualmem_portb_arb dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .we_i     (wev),
    .addr_i   (addrv),
    .len_i    (lenv),
    .wdata_i  (wdv),
    .gnt_o    (gnt_o),
    .beat_o   (beat_o),
    .done_o   (done_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .enb_o    (enb_o),
    .web_o    (web_o),
    .addrb_o  (addrb_o),
    .dinb_o   (dinb_o),
    .doutb_i  (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [10:0] a);
    return {16'hC0DE, 5'b0, a, 16'h5A5A, 5'b0, ~a};
  endfunction

  // registered-read RAM, per-half write enables
  always @(posedge clk) begin
    if (enb_o) begin
      logic [63:0] cur;
      cur   = rw[addrb_o] ? ram[addrb_o] : pat(addrb_o);
      doutb <= cur;
      if (|web_o) begin
        if (web_o[0]) cur[31:0]  = dinb_o[31:0];
        if (web_o[1]) cur[63:32] = dinb_o[63:32];
        ram[addrb_o] <= cur;
        rw[addrb_o]  <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [10:0] a);
    return mw[a] ? model[a] : pat(a);
  endfunction

  // read return: pop expected data whenever rvalid shows
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", {$onehot0(gnt_o), $onehot0(beat_o),
                     $onehot0(rvalid_o)}, 3'b111);
      if (rvalid_o != 2'b00) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexp", {62'b0, rvalid_o}, 64'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("rvalid_who", {62'b0, rvalid_o}, 64'd1 << e.r);
          chk("rdata", rdata_o, e.d);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic beat_chk(input int r, input logic [1:0] we,
                          input logic [10:0] a, input logic [63:0] wd,
                          input bit last_b);
    logic [63:0] m;
    chk("beat", {62'b0, beat_o}, 64'd1 << r);
    chk("gnt_busy", {62'b0, gnt_o}, 64'd0);
    chk("enb", {63'b0, enb_o}, 64'd1);
    chk("addrb", {53'b0, addrb_o}, {53'b0, a});
    chk("web", {62'b0, web_o}, {62'b0, we});
    chk("dinb", dinb_o, (we == 2'b00) ? 64'd0 : wd);
    chk("done", {62'b0, done_o}, last_b ? (64'd1 << r) : 64'd0);
    if (we == 2'b00) begin
      sb.push_back('{r: r[0], d: mread(a)});
    end else begin
      m = mread(a);
      if (we[0]) m[31:0]  = wd[31:0];
      if (we[1]) m[63:32] = wd[63:32];
      model[a] = m;
      mw[a]    = 1'b1;
    end
  endtask

  // one full burst; entered and left just after a clock edge
  task automatic run_burst(input int r, input logic [1:0] we,
                           input logic [10:0] a, input logic [3:0] len,
                           input logic [63:0] wb, input int late);
    logic [10:0] ea;
    req[r]   = 1'b1;
    wev[r]   = we;
    addrv[r] = a;
    lenv[r]  = len;
    @(negedge clk);
    chk("gnt", {62'b0, gnt_o}, 64'd1 << r);
    chk("enb_gnt", {63'b0, enb_o}, 64'd0);
    @(posedge clk);
    #1;
    req[r]   = 1'b0;
    wev[r]   = ~we;
    addrv[r] = a ^ 11'h155;
    lenv[r]  = ~len;
    for (int k = 0; k <= int'(len); k++) begin
      wdv[r] = wb + 64'(k);
      if (k == late) req[1-r] = 1'b1;
      ea = a + 11'(k);
      @(negedge clk);
      beat_chk(r, we, ea, wb + 64'(k), k == int'(len));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wev   = '0;
    addrv = '0;
    lenv  = '0;
    wdv   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", {62'b0, gnt_o}, 64'd0);
    chk("rst_beat", {62'b0, beat_o}, 64'd0);
    chk("rst_done", {62'b0, done_o}, 64'd0);
    chk("rst_rvalid", {62'b0, rvalid_o}, 64'd0);
    chk("rst_enb", {63'b0, enb_o}, 64'd0);
    chk("rst_addrb", {53'b0, addrb_o}, 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    @(posedge clk);
    #1;

    // single read burst from preloaded words
    run_burst(0, 2'b00, 11'h005, 4'd3, 64'd0, -1);
    idle(2);
    do_reset();

    // tie: both requesting single-beat reads
    req      = 2'b11;
    wev      = '0;
    lenv     = '0;
    addrv[0] = 11'h020;
    addrv[1] = 11'h030;
    for (int c = 0; c < 10; c++) begin
      int o;
      o = (c / 2) % 2;
      if (c == 9) req = 2'b00;
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("tie_gnt", {62'b0, gnt_o}, 64'd1 << o);
        chk("tie_nobeat", {62'b0, beat_o}, 64'd0);
      end else begin
        chk("tie_gnt0", {62'b0, gnt_o}, 64'd0);
        beat_chk(o, 2'b00, o ? 11'h030 : 11'h020, 64'd0, 1'b1);
      end
      @(posedge clk);
      #1;
    end
    req = 2'b00;
    idle(2);

    // full write wrapping past the top, then read back
    run_burst(1, 2'b11, 11'h7FE, 4'd2, 64'hA, -1);
    idle(1);
    run_burst(0, 2'b00, 11'h7FE, 4'd2, 64'd0, -1);
    idle(1);

    // half-word mask
    run_burst(0, 2'b11, 11'h010, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    run_burst(1, 2'b01, 11'h010, 4'd0, 64'h1111_2222_3333_4444, -1);
    run_burst(0, 2'b00, 11'h010, 4'd0, 64'd0, -1);
    chk("mask_model", mread(11'h010), 64'hFFFF_FFFF_3333_4444);
    idle(2);

    // reset on beat 5 of a 16-beat read
    req[0]   = 1'b1;
    wev[0]   = 2'b00;
    addrv[0] = 11'h100;
    lenv[0]  = 4'd15;
    @(negedge clk);
    chk("rb_gnt", {62'b0, gnt_o}, 64'd1);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      beat_chk(0, 2'b00, 11'h100 + 11'(k), 64'd0, 1'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rb_enb", {63'b0, enb_o}, 64'd0);
    chk("rb_beat", {62'b0, beat_o}, 64'd0);
    chk("rb_done", {62'b0, done_o}, 64'd0);
    chk("rb_rvalid", {62'b0, rvalid_o}, 64'd0);
    chk("rb_rdata", rdata_o, 64'd0);
    chk("rb_gnt0", {62'b0, gnt_o}, 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rb_quiet", {enb_o, done_o, beat_o}, 64'd0);
      @(posedge clk);
      #1;
    end
    run_burst(0, 2'b00, 11'h123, 4'd1, 64'd0, -1);
    idle(1);

    // late request waits for the bubble after done
    wev[1]   = 2'b00;
    addrv[1] = 11'h040;
    lenv[1]  = 4'd1;
    run_burst(0, 2'b00, 11'h200, 4'd7, 64'd0, 3);
    run_burst(1, 2'b00, 11'h040, 4'd1, 64'd0, -1);

    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
